// File: rtl/buzzer_tone_gen_if.sv
// Control bits from the buzzer's bus registers plus the pin-side status of the tone generator.
interface buzzer_tone_gen_if;
    logic ctrl_en;
    logic ctrl_buzz;
    logic buzzer_out;
    logic active;

    modport master (output ctrl_en, output ctrl_buzz, input buzzer_out, input active);
    modport slave  (input ctrl_en, input ctrl_buzz, output buzzer_out, output active);
endinterface

// File: rtl/buzzer_tone_gen.sv
// Piezo square-wave driver with period-aligned graceful stops and a guaranteed minimum tone length.
// Defining BUZZER_CADENCE_EN adds an on/off burst cadence inside the tone.
module buzzer_tone_gen #(
    parameter int HALF_PERIOD_CYCLES  = 12500,
    parameter int MIN_PERIODS         = 2,
    parameter int CADENCE_ON_PERIODS  = 200,
    parameter int CADENCE_OFF_PERIODS = 200
) (
    input logic         clk,
    input logic         rst,
    buzzer_tone_gen_if.slave bus
);

    localparam int HC_W = (HALF_PERIOD_CYCLES > 1) ? $clog2(HALF_PERIOD_CYCLES) : 1;
    localparam int PC_W = $clog2(MIN_PERIODS + 1);

    if (HALF_PERIOD_CYCLES < 1 || MIN_PERIODS < 1 ||
        CADENCE_ON_PERIODS < 1 || CADENCE_OFF_PERIODS < 1) begin : g_param_check
        $error("buzzer_tone_gen: all parameters must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, TONE, STOP} state_t;

    state_t            state, state_next;
    logic [HC_W-1:0]   hc, hc_next;
    logic [PC_W-1:0]   pc, pc_next, pc_after;
    logic              phase, phase_next;
    logic              req, wrap, period_end, min_done, toggling;

`ifdef BUZZER_CADENCE_EN
    localparam int CC_MAX = (CADENCE_ON_PERIODS > CADENCE_OFF_PERIODS) ? CADENCE_ON_PERIODS : CADENCE_OFF_PERIODS;
    localparam int CC_W   = (CC_MAX > 1) ? $clog2(CC_MAX) : 1;

    logic              gap, gap_next;
    logic [CC_W-1:0]   cc, cc_next;
    logic              out_q;

    assign toggling       = ~gap;
    assign bus.buzzer_out = out_q;
`else
    assign toggling       = 1'b1;
    assign bus.buzzer_out = phase;
`endif

    // A period is a high half followed by a low half; it ends when the low half wraps.
    assign req        = bus.ctrl_en && bus.ctrl_buzz;
    assign wrap       = (hc == HC_W'(HALF_PERIOD_CYCLES - 1));
    assign period_end = wrap && !phase;
    assign pc_after   = (toggling && pc != PC_W'(MIN_PERIODS)) ? pc + 1'b1 : pc;
    assign min_done   = (pc_after == PC_W'(MIN_PERIODS));
    assign bus.active = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        hc_next    = hc;
        pc_next    = pc;
        phase_next = phase;
`ifdef BUZZER_CADENCE_EN
        gap_next   = gap;
        cc_next    = cc;
`endif
        case (state)
            IDLE: begin
                hc_next    = '0;
                pc_next    = '0;
                phase_next = 1'b0;
`ifdef BUZZER_CADENCE_EN
                gap_next   = 1'b0;
                cc_next    = '0;
`endif
                if (req) begin
                    state_next = TONE;
                    phase_next = 1'b1;
                end
            end
            TONE, STOP: begin
                hc_next = wrap ? '0 : hc + 1'b1;
                if (wrap)
                    phase_next = ~phase;
                if (period_end) begin
                    pc_next = pc_after;
`ifdef BUZZER_CADENCE_EN
                    if (!gap) begin
                        if (cc == CC_W'(CADENCE_ON_PERIODS - 1)) begin
                            gap_next = 1'b1;
                            cc_next  = '0;
                        end else begin
                            cc_next  = cc + 1'b1;
                        end
                    end else begin
                        if (cc == CC_W'(CADENCE_OFF_PERIODS - 1)) begin
                            gap_next = 1'b0;
                            cc_next  = '0;
                        end else begin
                            cc_next  = cc + 1'b1;
                        end
                    end
`endif
                end
                // A renewed request in STOP wins over completion so the tone never drops out.
                if (state == TONE) begin
                    if (!req)
                        state_next = STOP;
                end else if (req) begin
                    state_next = TONE;
                end else if (period_end && min_done) begin
                    state_next = IDLE;
                    hc_next    = '0;
                    pc_next    = '0;
                    phase_next = 1'b0;
`ifdef BUZZER_CADENCE_EN
                    gap_next   = 1'b0;
                    cc_next    = '0;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc    <= '0;
            pc    <= '0;
            phase <= 1'b0;
`ifdef BUZZER_CADENCE_EN
            gap   <= 1'b0;
            cc    <= '0;
            out_q <= 1'b0;
`endif
        end else begin
            hc    <= hc_next;
            pc    <= pc_next;
            phase <= phase_next;
`ifdef BUZZER_CADENCE_EN
            gap   <= gap_next;
            cc    <= cc_next;
            out_q <= phase_next & ~gap_next;
`endif
        end
    end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Bench for buzzer_tone_gen: three parameterisations share one stimulus stream, each checked
// every cycle against a period-position model, plus hand-computed vectors and corner sequences.
module tb_buzzer_tone_gen;

    logic clk;
    logic rst;
    logic en;
    logic buzz;
    int   checks;
    int   errors;

    buzzer_tone_gen_if if_a ();
    buzzer_tone_gen_if if_b ();
    buzzer_tone_gen_if if_c ();

    assign if_a.ctrl_en   = en;
    assign if_a.ctrl_buzz = buzz;
    assign if_b.ctrl_en   = en;
    assign if_b.ctrl_buzz = buzz;
    assign if_c.ctrl_en   = en;
    assign if_c.ctrl_buzz = buzz;

    buzzer_tone_gen #(.HALF_PERIOD_CYCLES(4), .MIN_PERIODS(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    buzzer_tone_gen #(.HALF_PERIOD_CYCLES(3), .MIN_PERIODS(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    buzzer_tone_gen #(.HALF_PERIOD_CYCLES(1), .MIN_PERIODS(2)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    logic [2:0] obs_out;
    logic [2:0] obs_act;
    assign obs_out = {if_c.buzzer_out, if_b.buzzer_out, if_a.buzzer_out};
    assign obs_act = {if_c.active, if_b.active, if_a.active};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit busy;
        bit stopping;
        int t;
        int done;
    } model_t;

    typedef struct packed {
        logic out;
        logic act;
    } exp_t;

    typedef struct {
        logic en;
        logic buzz;
        int   cycles;
        logic exp_out;
        logic exp_act;
    } vec_t;

    model_t mdl [3];
    exp_t   exp_q [$];
    vec_t   vecs [14];
    int     act_count [3];

    function automatic int halfOf(input int k);
        case (k)
            0:       return 4;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int minOf(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int expCount(input int k);
        return 2 * halfOf(k) * minOf(k);
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mdl[k].busy     = 1'b0;
            mdl[k].stopping = 1'b0;
            mdl[k].t        = 0;
            mdl[k].done     = 0;
        end
    endtask

    // t is the cycle position inside the current full period; output is high in the first half.
    task automatic modelStep(input int k, input bit req);
        bit was_stop;
        if (!mdl[k].busy) begin
            if (req) begin
                mdl[k].busy     = 1'b1;
                mdl[k].stopping = 1'b0;
                mdl[k].t        = 0;
                mdl[k].done     = 0;
            end
        end else begin
            was_stop        = mdl[k].stopping;
            mdl[k].t        = mdl[k].t + 1;
            mdl[k].stopping = !req;
            if (mdl[k].t == 2 * halfOf(k)) begin
                mdl[k].t    = 0;
                mdl[k].done = mdl[k].done + 1;
                if (was_stop && !req && mdl[k].done >= minOf(k)) begin
                    mdl[k].busy     = 1'b0;
                    mdl[k].stopping = 1'b0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit req);
        exp_t x;
        for (int k = 0; k < 3; k++) begin
            modelStep(k, req);
            x.out = mdl[k].busy && (mdl[k].t < halfOf(k));
            x.act = mdl[k].busy;
            exp_q.push_back(x);
        end
    endtask

    task automatic checkOutput(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0b exp=%0b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic drainCheck();
        exp_t x;
        for (int k = 0; k < 3; k++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_empty dut=%0d got=none exp=entry", k);
            end else begin
                x = exp_q.pop_front();
                checkOutput($sformatf("scb_out_dut%0d", k), obs_out[k], x.out);
                checkOutput($sformatf("scb_act_dut%0d", k), obs_act[k], x.act);
            end
        end
    endtask

    task automatic runCycle(input logic e, input logic b);
        @(negedge clk);
        en   = e;
        buzz = b;
        applyStimulus(e && b);
        @(posedge clk);
        #1;
        drainCheck();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        en     = 1'b0;
        buzz   = 1'b0;
        checks = 0;
        errors = 0;
        modelReset();

        // Hand-computed expectations for dut_a (half period 4, minimum 1 period).
        vecs[0]  = '{1'b1, 1'b0,  3, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1,  5, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1,  1, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1,  3, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b1,  1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 36, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0,  2, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1,  2, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1,  3, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1,  8, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0,  1, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0,  7, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0,  1, 1'b0, 1'b0};

        #1 rst = 1'b1;
        #11;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("reset_out_dut%0d", k), obs_out[k], 1'b0);
            checkOutput($sformatf("reset_act_dut%0d", k), obs_act[k], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            repeat (vecs[i].cycles) runCycle(vecs[i].en, vecs[i].buzz);
            checkOutput($sformatf("vec%0d_out", i), obs_out[0], vecs[i].exp_out);
            checkOutput($sformatf("vec%0d_act", i), obs_act[0], vecs[i].exp_act);
        end

        // A one-cycle request must still play exactly the minimum number of full periods.
        for (int k = 0; k < 3; k++) act_count[k] = 0;
        runCycle(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) act_count[k] += int'(obs_act[k]);
        repeat (19) begin
            runCycle(1'b1, 1'b0);
            for (int k = 0; k < 3; k++) act_count[k] += int'(obs_act[k]);
        end
        for (int k = 0; k < 3; k++)
            checkCount($sformatf("minlen_active_cycles_dut%0d", k), act_count[k], expCount(k));

        // Reset between clock edges must silence the pin without waiting for an edge.
        runCycle(1'b1, 1'b1);
        runCycle(1'b1, 1'b1);
        checkOutput("pre_reset_out_dut0", obs_out[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("async_rst_out_dut%0d", k), obs_out[k], 1'b0);
            checkOutput($sformatf("async_rst_act_dut%0d", k), obs_act[k], 1'b0);
        end
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("rst_held_out_dut0", obs_out[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(en && buzz);
        @(posedge clk);
        #1;
        drainCheck();
        repeat (5) runCycle(1'b1, 1'b1);
        repeat (20) runCycle(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("final_out_dut%0d", k), obs_out[k], 1'b0);
            checkOutput($sformatf("final_act_dut%0d", k), obs_act[k], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
